// File: rtl/mmu_dcache_e2_responder.sv
// mmu_dcache_e2_responder: E1/E2 dcache responder with 8-entry DTLB, miss refill window and trap reporting
module mmu_dcache_e2_responder #(
  parameter int NB_ENTRIES   = 8,
  parameter int PAGE_SHIFT   = 12,
  parameter int MISS_LATENCY = 4,
  localparam int IW = $clog2(NB_ENTRIES),
  localparam int VW = 41 - PAGE_SHIFT,
  localparam int CW = $clog2(MISS_LATENCY + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          e1_dcache_req_i,
  input  logic [40:0]   e1_dcache_virt_addr_i,
  input  logic          e1_glob_acc_i,
  input  logic [3:0]    e1_dcache_size_i,
  input  logic          e1_non_trapping_i,
  input  logic [5:0]    e1_dcache_opc_i,
  input  logic          dcache_e3_stall_i,
  input  logic          tlb_wr_i,
  input  logic [IW-1:0] tlb_wr_idx_i,
  input  logic [VW-1:0] tlb_wr_vpn_i,
  input  logic [3:0]    tlb_wr_flags_i,
  output logic          dcache_e1_grant_o,
  output logic          e2_stall_o,
  output logic          e2_non_trapping_id_cancel_o,
  output logic [1:0]    e2_trap_nomapping_o,
  output logic [1:0]    e2_trap_protection_o,
  output logic [1:0]    e2_trap_writetoclean_o,
  output logic [1:0]    e2_trap_atomictoclean_o,
  output logic          e2_trap_dmisalign_o,
  output logic [1:0]    e2_trap_dsyserror_o
);
  typedef enum logic [1:0] {IDLE, LOOKUP, MISS, RESULT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0] opc_q, opc_d;
  logic [VW-1:0] vpn_q, vpn_d;
  logic [3:0] off_q, off_d, size_q, size_d;
  logic gacc_q, gacc_d, nt_q, nt_d;
  logic [NB_ENTRIES-1:0] tv_q, tv_d, tg_q, tg_d, tw_q, tw_d, td_q, td_d;
  logic [NB_ENTRIES-1:0][VW-1:0] tvpn_q, tvpn_d;
  logic [IW:0] nhit;
  logic [IW-1:0] hidx;
  logic is_store, is_at, is_dzerol, is_touch, is_line, is_wr, is_load;
  logic size_ok, misalign, hit, multi, ok, t_sys, t_nomap, t_prot, t_wtc, t_atc;
  logic res_cycle, show, unused_addr;
  logic [1:0] lane;
  assign unused_addr = ^e1_dcache_virt_addr_i[PAGE_SHIFT-1:4];
  assign is_store  = opc_q == 6'b000010;
  assign is_at     = opc_q == 6'b000011 || opc_q == 6'b000111 || opc_q == 6'b001111;
  assign is_dzerol = opc_q == 6'b100000;
  assign is_touch  = opc_q == 6'b011100;
  assign is_line   = is_dzerol || is_touch || opc_q == 6'b011000 || opc_q == 6'b111000 || opc_q == 6'b001000;
  assign is_wr     = is_store || is_dzerol;
  assign is_load   = !is_line && !is_store && !is_at;
  always_comb begin
    nhit = '0;
    hidx = '0;
    for (int i = 0; i < NB_ENTRIES; i++)
      if (tv_q[i] && tvpn_q[i] == vpn_q && (tg_q[i] || !gacc_q)) begin
        nhit = nhit + 1'b1;
        hidx = IW'(i);
      end
  end
  assign size_ok  = size_q == 4'd1 || size_q == 4'd2 || size_q == 4'd4 || size_q == 4'd8;
  assign misalign = !is_line && (!size_ok || (off_q & (size_q - 4'd1)) != 4'd0);
  assign hit      = nhit != '0;
  assign multi    = nhit > (IW+1)'(1);
  assign ok       = !misalign && hit && !multi;
  assign t_sys    = !misalign && multi;
  assign t_nomap  = !misalign && !hit;
  assign t_prot   = ok && (is_wr || is_at) && !tw_q[hidx];
  assign t_wtc    = ok && is_wr && tw_q[hidx] && !td_q[hidx];
  assign t_atc    = ok && is_at && tw_q[hidx] && !td_q[hidx];
  // A miss in the first E2 cycle is not a result; the re-lookup in RESULT reports it.
  assign res_cycle = (state_q == LOOKUP && (misalign || hit)) || state_q == RESULT;
  assign e2_non_trapping_id_cancel_o = res_cycle && is_load && nt_q && (t_sys || t_nomap || t_prot || t_wtc || t_atc);
  assign show = res_cycle && !is_touch && !e2_non_trapping_id_cancel_o;
  assign lane = is_line ? 2'b10 : 2'b01;
  assign e2_trap_dmisalign_o     = show && misalign;
  assign e2_trap_dsyserror_o     = (show && t_sys) ? lane : 2'b00;
  assign e2_trap_nomapping_o     = (show && t_nomap) ? lane : 2'b00;
  assign e2_trap_protection_o    = (show && t_prot) ? lane : 2'b00;
  assign e2_trap_writetoclean_o  = (show && t_wtc) ? lane : 2'b00;
  assign e2_trap_atomictoclean_o = (show && t_atc) ? lane : 2'b00;
  assign e2_stall_o        = (state_q == LOOKUP && !misalign && !hit) || state_q == MISS;
  assign dcache_e1_grant_o = e1_dcache_req_i && !e2_stall_o && !dcache_e3_stall_i;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opc_d   = opc_q;
    vpn_d   = vpn_q;
    off_d   = off_q;
    size_d  = size_q;
    gacc_d  = gacc_q;
    nt_d    = nt_q;
    if (!dcache_e3_stall_i) begin
      if (state_q == MISS) begin
        cnt_d   = cnt_q + CW'(1);
        state_d = cnt_d == CW'(MISS_LATENCY) ? RESULT : MISS;
      end else if (e2_stall_o) begin
        cnt_d   = CW'(1);
        state_d = MISS_LATENCY == 1 ? RESULT : MISS;
      end else
        state_d = dcache_e1_grant_o ? LOOKUP : IDLE;
    end
    if (dcache_e1_grant_o) begin
      opc_d  = e1_dcache_opc_i;
      vpn_d  = e1_dcache_virt_addr_i[40:PAGE_SHIFT];
      off_d  = e1_dcache_virt_addr_i[3:0];
      size_d = e1_dcache_size_i;
      gacc_d = e1_glob_acc_i;
      nt_d   = e1_non_trapping_i;
    end
  end
  always_comb begin
    tv_d   = tv_q;
    tg_d   = tg_q;
    tw_d   = tw_q;
    td_d   = td_q;
    tvpn_d = tvpn_q;
    if (tlb_wr_i) begin
      {tv_d[tlb_wr_idx_i], tg_d[tlb_wr_idx_i], tw_d[tlb_wr_idx_i], td_d[tlb_wr_idx_i]} = tlb_wr_flags_i;
      tvpn_d[tlb_wr_idx_i] = tlb_wr_vpn_i;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opc_q   <= '0;
      vpn_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      gacc_q  <= 1'b0;
      nt_q    <= 1'b0;
      tv_q    <= '0;
      tg_q    <= '0;
      tw_q    <= '0;
      td_q    <= '0;
      tvpn_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opc_q   <= opc_d;
      vpn_q   <= vpn_d;
      off_q   <= off_d;
      size_q  <= size_d;
      gacc_q  <= gacc_d;
      nt_q    <= nt_d;
      tv_q    <= tv_d;
      tg_q    <= tg_d;
      tw_q    <= tw_d;
      td_q    <= td_d;
      tvpn_q  <= tvpn_d;
    end
  end
endmodule

// File: tb/tb_mmu_dcache_e2_responder.sv
// tb_mmu_dcache_e2_responder: directed and random transactions checked against a transaction-level DTLB/trap model
module tb_mmu_dcache_e2_responder;
  localparam int ML = 4;
  localparam logic [5:0] LOAD = 6'b000001, STORE = 6'b000010, LDC = 6'b000011, FDA = 6'b000111, CWS = 6'b001111;
  localparam logic [5:0] DZEROL = 6'b100000, DINVALL = 6'b011000, DTOUCHL = 6'b011100, DINVAL = 6'b111000, WPURGE = 6'b001000;
  localparam logic [5:0] OPS [11] = '{LOAD, STORE, LDC, FDA, CWS, DZEROL, DINVALL, DTOUCHL, DINVAL, WPURGE, 6'b010101};
  localparam logic [3:0] SZS [8] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd8, 4'd3, 4'd0, 4'd8};
  typedef struct packed {
    logic mis;
    logic [3:0] hits;
    logic [1:0] nm, pr, wc, ac, sy;
    logic cn;
  } exp_t;
  logic clock = 1'b0, reset = 1'b1, req = 1'b0, glob = 1'b0, nt = 1'b0, e3 = 1'b0, wr = 1'b0;
  logic [40:0] addr = '0;
  logic [3:0] size = '0, wfl = '0;
  logic [5:0] opc = '0;
  logic [2:0] widx = '0;
  logic [28:0] wvpn = '0;
  logic grant, stall, cancel, dmis;
  logic [1:0] nm, pr, wc, ac, sy;
  logic m_v [8], m_g [8], m_w [8], m_d [8];
  logic [28:0] m_vpn [8];
  int n_chk = 0, n_err = 0;
  always #5 clock = ~clock;
  mmu_dcache_e2_responder dut (
    .clock(clock), .reset(reset),
    .e1_dcache_req_i(req), .e1_dcache_virt_addr_i(addr), .e1_glob_acc_i(glob),
    .e1_dcache_size_i(size), .e1_non_trapping_i(nt), .e1_dcache_opc_i(opc),
    .dcache_e3_stall_i(e3), .tlb_wr_i(wr), .tlb_wr_idx_i(widx), .tlb_wr_vpn_i(wvpn), .tlb_wr_flags_i(wfl),
    .dcache_e1_grant_o(grant), .e2_stall_o(stall), .e2_non_trapping_id_cancel_o(cancel),
    .e2_trap_nomapping_o(nm), .e2_trap_protection_o(pr), .e2_trap_writetoclean_o(wc),
    .e2_trap_atomictoclean_o(ac), .e2_trap_dmisalign_o(dmis), .e2_trap_dsyserror_o(sy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask
  function automatic exp_t predict(input logic [5:0] o, input logic [40:0] a, input logic [3:0] sz, input logic ga, input logic ntr);
    exp_t e;
    logic line, wrt, atm, ld;
    logic [1:0] lane;
    int k, kind;
    e = '0;
    line = o inside {DZEROL, DINVALL, DTOUCHL, DINVAL, WPURGE};
    wrt = o inside {STORE, DZEROL};
    atm = o inside {LDC, FDA, CWS};
    ld = !line && !wrt && !atm;
    lane = line ? 2'b10 : 2'b01;
    e.mis = !line && (!(sz inside {4'd1, 4'd2, 4'd4, 4'd8}) || (int'(a[3:0]) % int'(sz)) != 0);
    k = 0;
    for (int i = 0; i < 8; i++)
      if (m_v[i] && m_vpn[i] == a[40:12] && (m_g[i] || !ga)) begin
        e.hits = e.hits + 4'd1;
        k = i;
      end
    kind = 0;
    if (e.mis) kind = 0;
    else if (e.hits > 1) kind = 1;
    else if (e.hits == 0) kind = 2;
    else if ((wrt || atm) && !m_w[k]) kind = 3;
    else if (wrt && !m_d[k]) kind = 4;
    else if (atm && !m_d[k]) kind = 5;
    if (o == DTOUCHL) e.mis = 1'b0;
    else if (ld && ntr && kind != 0) e.cn = 1'b1;
    else
      case (kind)
        1: e.sy = lane;
        2: e.nm = lane;
        3: e.pr = lane;
        4: e.wc = lane;
        5: e.ac = lane;
        default: ;
      endcase
    return e;
  endfunction
  task automatic model_wr(input logic [2:0] i, input logic [28:0] v, input logic [3:0] f);
    {m_v[i], m_g[i], m_w[i], m_d[i]} = f;
    m_vpn[i] = v;
  endtask
  task automatic tlb_write(input logic [2:0] i, input logic [28:0] v, input logic [3:0] f);
    wr = 1'b1; widx = i; wvpn = v; wfl = f;
    @(posedge clock); #1;
    model_wr(i, v, f);
    wr = 1'b0;
  endtask
  task automatic do_reset;
    reset = 1'b1; req = 1'b0; wr = 1'b0; e3 = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) m_v[i] = 1'b0;
  endtask
  task automatic check_result(input string tag, input exp_t e);
    chk({tag, "_nomap"}, nm, e.nm);
    chk({tag, "_prot"}, pr, e.pr);
    chk({tag, "_wtc"}, wc, e.wc);
    chk({tag, "_atc"}, ac, e.ac);
    chk({tag, "_dsys"}, sy, e.sy);
    chk({tag, "_dmis"}, dmis, e.mis);
    chk({tag, "_cancel"}, cancel, e.cn);
  endtask
  task automatic txn(input string tag, input logic [5:0] o, input logic [40:0] a, input logic [3:0] sz,
                     input logic ga, input logic ntr, input int wr_at,
                     input logic [2:0] wi, input logic [28:0] wv, input logic [3:0] wf);
    exp_t e;
    int n;
    req = 1'b1; opc = o; addr = a; size = sz; glob = ga; nt = ntr;
    @(negedge clock);
    chk({tag, "_grant"}, grant, 1);
    @(posedge clock); #1;
    req = 1'b0;
    e = predict(o, a, sz, ga, ntr);
    n = 0;
    @(negedge clock);
    while (stall && n < 4 * ML) begin
      n++;
      req = 1'b1; #1;
      chk({tag, "_grant_in_stall"}, grant, 0);
      req = 1'b0;
      if (n == wr_at) begin wr = 1'b1; widx = wi; wvpn = wv; wfl = wf; end
      @(posedge clock); #1;
      if (wr) begin model_wr(widx, wvpn, wfl); wr = 1'b0; end
      @(negedge clock);
    end
    chk({tag, "_stall_len"}, n, (!e.mis && e.hits == 0) ? ML : 0);
    check_result(tag, predict(o, a, sz, ga, ntr));
    @(posedge clock); #1;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    do_reset;
    @(negedge clock);
    chk("reset_outs", {nm, pr, wc, ac, sy, dmis, cancel, stall, grant}, 0);
    @(posedge clock); #1;
    tlb_write(3'd0, 29'h10, 4'b1011);
    txn("load_hit", LOAD, 41'h10008, 4'd8, 1'b0, 1'b0, 0, 3'd0, '0, '0);
    txn("store_misalign", STORE, 41'h10004, 4'd8, 1'b0, 1'b0, 0, 3'd0, '0, '0);
    txn("load_miss", LOAD, 41'h20000, 4'd8, 1'b0, 1'b0, 0, 3'd0, '0, '0);
    txn("load_refill", LOAD, 41'h20000, 4'd8, 1'b0, 1'b0, 2, 3'd1, 29'h20, 4'b1011);
    txn("glob_nonglobal", LOAD, 41'h10008, 4'd8, 1'b1, 1'b0, 0, 3'd0, '0, '0);
    tlb_write(3'd2, 29'h40, 4'b1010);
    tlb_write(3'd3, 29'h50, 4'b1000);
    txn("dzerol_wtc", DZEROL, 41'h40000, 4'd8, 1'b0, 1'b0, 0, 3'd0, '0, '0);
    txn("cws_prot", CWS, 41'h50000, 4'd8, 1'b0, 1'b0, 0, 3'd0, '0, '0);
    tlb_write(3'd4, 29'h30, 4'b1011);
    tlb_write(3'd5, 29'h30, 4'b1111);
    txn("ldc_multihit", LDC, 41'h30000, 4'd8, 1'b0, 1'b0, 0, 3'd0, '0, '0);
    txn("nt_load_cancel", LOAD, 41'h60000, 4'd8, 1'b0, 1'b1, 0, 3'd0, '0, '0);
    txn("dtouchl_hint", DTOUCHL, 41'h60000, 4'd8, 1'b0, 1'b0, 0, 3'd0, '0, '0);
    req = 1'b1; opc = LOAD; addr = 41'h10008; size = 4'd8; glob = 1'b0; nt = 1'b0;
    @(negedge clock);
    chk("b2b_grant1", grant, 1);
    @(posedge clock); #1;
    opc = STORE; addr = 41'h10004;
    @(negedge clock);
    chk("b2b_grant2", grant, 1);
    chk("b2b_res1", {nm, pr, wc, ac, sy, dmis, cancel, stall}, 0);
    @(posedge clock); #1;
    req = 1'b0;
    @(negedge clock);
    chk("b2b_res2_dmis", dmis, 1);
    @(posedge clock); #1;
    req = 1'b1; opc = STORE; addr = 41'h10004; size = 4'd8;
    @(negedge clock);
    chk("e3_grant", grant, 1);
    @(posedge clock); #1;
    req = 1'b0; e3 = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("e3_hold_dmis", dmis, 1);
      req = 1'b1; #1;
      chk("e3_grant_low", grant, 0);
      req = 1'b0;
      @(posedge clock); #1;
    end
    e3 = 1'b0;
    @(negedge clock);
    chk("e3_release_dmis", dmis, 1);
    @(posedge clock); #1;
    @(negedge clock);
    chk("e3_idle_dmis", dmis, 0);
    @(posedge clock); #1;
    req = 1'b1; opc = LOAD; addr = 41'h70000; size = 4'd8;
    @(negedge clock);
    chk("rstmiss_grant", grant, 1);
    @(posedge clock); #1;
    req = 1'b0;
    @(negedge clock);
    chk("rstmiss_stall1", stall, 1);
    @(posedge clock); #1;
    @(negedge clock);
    chk("rstmiss_stall2", stall, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) m_v[i] = 1'b0;
    @(negedge clock);
    chk("rst_outs", {nm, pr, wc, ac, sy, dmis, cancel, stall}, 0);
    req = 1'b1; #1;
    chk("rst_grant", grant, 1);
    req = 1'b0;
    repeat (ML + 1) begin @(posedge clock); #1; end
    @(negedge clock);
    chk("rst_no_result", {nm, pr, wc, ac, sy, dmis, cancel, stall}, 0);
    @(posedge clock); #1;
    do_reset;
    for (int i = 0; i < 8; i++)
      tlb_write(3'(i), 29'h100 + 29'($urandom_range(0, 5)), {1'($urandom_range(0, 3) != 0), 3'($urandom)});
    for (int t = 0; t < 150; t++)
      txn("rnd", OPS[$urandom_range(0, 10)], {29'h100 + 29'($urandom_range(0, 7)), 12'($urandom_range(0, 15))},
          SZS[$urandom_range(0, 7)], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 6)), 3'($urandom), 29'h100 + 29'($urandom_range(0, 7)), 4'($urandom));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
